// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared constants and types for the SPI responder: byte width,
//             mode-3 clock polarity/phase, frame state encoding and the
//             byte substituted on MISO when nothing is queued.
//  Revision : 1.0  initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    // Mode 3: SCLK idles high, data is launched on falling edges and
    // captured on rising edges.
    localparam logic SPI_CPOL = 1'b1;
    localparam logic SPI_CPHA = 1'b1;

    localparam logic [SPI_BYTE_W-1:0] SPI_DEFAULT_TX = 8'h00;

    typedef enum logic [0:0] {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_sync_edge
//  Purpose  : Synchronises one asynchronous pin into the clk domain and
//             produces single-cycle rise/fall pulses.
//  Ports    : clk, rst      - system clock, async active-high reset
//             din           - asynchronous input pin
//             rise / fall   - combinational edge pulses (synchronised value
//                             versus its previous value)
//  Revision : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,    // must be at least 2
    parameter logic IDLE_VAL    = 1'b1  // pin level assumed out of reset
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;
    logic                   w_sync;

    // Preset to the idle level so leaving reset never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= {SYNC_STAGES{IDLE_VAL}};
            r_prev  <= IDLE_VAL;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], din};
            r_prev  <= w_sync;
        end
    end

    assign w_sync = r_chain[SYNC_STAGES-1];
    assign rise   =  w_sync & ~r_prev;
    assign fall   = ~w_sync &  r_prev;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_slave_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_slave_responder
//  Purpose  : Mode-3 SPI slave that oversamples the SPI pins with clk and
//             exchanges whole bytes with the fabric.
//  Ports    : clk, rst            - system clock, async active-high reset
//             spi_clk, cs, mosi   - SPI pins from the master (async)
//             miso, miso_oe       - SPI data back to the master + enable
//             tx_data/valid/ready - one-byte transmit holding buffer
//             rx_data, rx_valid   - last received byte + one-clk strobe
//             busy                - frame in progress
//             tx_underrun         - DEFAULT_TX substituted (pulse)
//             frame_abort         - cs rose mid-byte (pulse)
//  Revision : 1.0  initial release
// ============================================================================
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int                    SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_W-1:0] DEFAULT_TX  = SPI_DEFAULT_TX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_clk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun,
    output logic                  frame_abort
);

    localparam int c_CNT_W = $clog2(SPI_BYTE_W);

    // ---------------------------------------------------------------- sync
    logic                   w_sclk_rise, w_sclk_fall;
    logic                   w_cs_rise, w_cs_fall;
    logic [SYNC_STAGES-1:0] r_mosi_chain;
    logic                   w_mosi_sync;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(SPI_CPOL)) u_sclk_sync (
        .clk (clk), .rst (rst), .din (spi_clk),
        .rise(w_sclk_rise), .fall(w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs_sync (
        .clk (clk), .rst (rst), .din (cs),
        .rise(w_cs_rise), .fall(w_cs_fall)
    );

    // mosi needs no edge detect; its chain has the same depth as the
    // spi_clk chain so the sampled bit lines up with the detected edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_mosi_chain <= '0;
        else     r_mosi_chain <= {r_mosi_chain[SYNC_STAGES-2:0], mosi};
    end
    assign w_mosi_sync = r_mosi_chain[SYNC_STAGES-1];

    // ------------------------------------------------------------ state
    spi_state_t              r_state, w_state_nxt;
    logic                    r_miso, w_miso_nxt;
    logic [SPI_BYTE_W-1:0]   r_tx_shift, w_tx_shift_nxt;
    logic [c_CNT_W-1:0]      r_tx_bits, w_tx_bits_nxt;
    logic [SPI_BYTE_W-2:0]   r_rx_shift, w_rx_shift_nxt;
    logic [c_CNT_W-1:0]      r_rx_bits, w_rx_bits_nxt;
    logic [SPI_BYTE_W-1:0]   r_rx_data, w_rx_data_nxt;
    logic                    r_rx_valid, w_rx_valid_nxt;
    logic                    r_underrun, w_underrun_nxt;
    logic                    r_abort, w_abort_nxt;
    logic [SPI_BYTE_W-1:0]   r_hold;
    logic                    r_full;
    logic                    w_fetch_hold;
    logic                    w_hold_wr;
    logic [SPI_BYTE_W-1:0]   w_tx_byte;
    logic [SPI_BYTE_W-1:0]   w_rx_byte;

    assign w_hold_wr = tx_valid && !r_full;
    assign w_rx_byte = {r_rx_shift, w_mosi_sync};

    always_comb begin
        w_state_nxt    = r_state;
        w_miso_nxt     = r_miso;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_bits_nxt  = r_tx_bits;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_bits_nxt  = r_rx_bits;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_underrun_nxt = 1'b0;
        w_abort_nxt    = 1'b0;
        w_fetch_hold   = 1'b0;
        w_tx_byte      = DEFAULT_TX;

        case (r_state)
            SPI_IDLE: begin
                // SCLK edges are ignored here, including one coincident
                // with the cs falling edge.
                if (w_cs_fall) begin
                    w_state_nxt   = SPI_ACTIVE;
                    w_tx_bits_nxt = '0;
                    w_rx_bits_nxt = '0;
                    w_miso_nxt    = 1'b1;
                end
            end
            SPI_ACTIVE: begin
                if (w_cs_rise) begin
                    // Deselect wins over any simultaneous SCLK edge.
                    w_state_nxt   = SPI_IDLE;
                    w_miso_nxt    = 1'b1;
                    w_tx_bits_nxt = '0;
                    w_rx_bits_nxt = '0;
                    w_abort_nxt   = (r_tx_bits != '0) || (r_rx_bits != '0);
                end else if (w_sclk_fall) begin
                    if (r_tx_bits == '0) begin
                        // Byte boundary: take the queued byte, or the
                        // default if the buffer is empty this very clk
                        // (a same-clk write lands in the buffer instead).
                        if (r_full) begin
                            w_tx_byte    = r_hold;
                            w_fetch_hold = 1'b1;
                        end else begin
                            w_underrun_nxt = 1'b1;
                        end
                        w_miso_nxt     = w_tx_byte[SPI_BYTE_W-1];
                        w_tx_shift_nxt = {w_tx_byte[SPI_BYTE_W-2:0], 1'b0};
                        w_tx_bits_nxt  = c_CNT_W'(1);
                    end else begin
                        w_miso_nxt     = r_tx_shift[SPI_BYTE_W-1];
                        w_tx_shift_nxt = {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
                        w_tx_bits_nxt  = r_tx_bits + c_CNT_W'(1);
                    end
                end else if (w_sclk_rise) begin
                    w_rx_shift_nxt = w_rx_byte[SPI_BYTE_W-2:0];
                    w_rx_bits_nxt  = r_rx_bits + c_CNT_W'(1);
                    if (r_rx_bits == c_CNT_W'(SPI_BYTE_W-1)) begin
                        w_rx_data_nxt  = w_rx_byte;
                        w_rx_valid_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = SPI_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SPI_IDLE;
            r_miso     <= 1'b1;
            r_tx_shift <= '0;
            r_tx_bits  <= '0;
            r_rx_shift <= '0;
            r_rx_bits  <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
            r_abort    <= 1'b0;
            r_hold     <= '0;
            r_full     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_miso     <= w_miso_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_bits  <= w_tx_bits_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_bits  <= w_rx_bits_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_underrun <= w_underrun_nxt;
            r_abort    <= w_abort_nxt;
            // Fetch only happens when full, write only when empty, so the
            // two never collide on the same clk.
            if (w_fetch_hold) begin
                r_full <= 1'b0;
            end else if (w_hold_wr) begin
                r_full <= 1'b1;
                r_hold <= tx_data;
            end
        end
    end

    assign miso        = r_miso;
    assign miso_oe     = (r_state == SPI_ACTIVE);
    assign busy        = (r_state == SPI_ACTIVE);
    assign tx_ready    = !r_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_underrun;
    assign frame_abort = r_abort;

endmodule : spi_slave_responder
`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave_responder
//  Purpose  : Self-checking bench for spi_slave_responder. Acts as a mode-3
//             SPI master and fabric; expected MISO bytes and underruns come
//             from a queue model of the transmit holding buffer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave_responder;

    localparam int         SYNC = 2;
    localparam int         HALF = 12;      // SCLK half-period in clk cycles
    localparam logic [7:0] DEF  = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_clk = 1'b1;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, frame_abort;
    logic [7:0] rx_data;

    spi_slave_responder #(.SYNC_STAGES(SYNC), .DEFAULT_TX(DEF)) dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .tx_underrun(tx_underrun), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int rxv_cnt = 0, und_cnt = 0, abt_cnt = 0, oe_cnt = 0;
    logic [7:0] rx_got[$];
    logic [7:0] model_q[$];
    logic [7:0] mo_buf[4], mi_buf[4], exp_buf[4];

    typedef struct {
        bit         queue;
        logic [7:0] qdata;
        logic [7:0] mo;
        logic [7:0] exp_mi;
        int         exp_und;
    } vec_t;
    vec_t vec[4];

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            rx_got.push_back(rx_data);
        end
        if (tx_underrun) und_cnt++;
        if (frame_abort) abt_cnt++;
        if (miso_oe)     oe_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        check("tx_ready before write", tx_ready, model_q.size() == 0);
        tx_data  = b;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        model_q.push_back(b);
    endtask

    // One byte as the master: drive on SCLK fall, sample MISO at SCLK rise.
    task automatic xfer_byte(input int b, input bit inject, input logic [7:0] inj);
        for (int i = 7; i >= 0; i--) begin
            spi_clk = 1'b0;
            mosi    = mo_buf[b][i];
            if (inject && i == 7) begin
                // Land the write on the very clk that registers the fetch.
                repeat (SYNC) @(posedge clk);
                #1;
                tx_data  = inj;
                tx_valid = 1'b1;
                @(posedge clk);
                #1;
                tx_valid = 1'b0;
                wait_clk(HALF - SYNC - 1);
            end else begin
                wait_clk(HALF);
            end
            mi_buf[b][i] = miso;
            spi_clk = 1'b1;
            wait_clk(HALF);
        end
    endtask

    task automatic run_frame(input int n, input bit inject, input logic [7:0] inj);
        int und0;
        int exp_und;
        und0    = und_cnt;
        exp_und = 0;
        rx_got.delete();
        for (int b = 0; b < n; b++) begin
            if (b == 0 && inject) begin
                exp_buf[b] = DEF;
                exp_und++;
                model_q.push_back(inj);
            end else if (model_q.size() > 0) begin
                exp_buf[b] = model_q.pop_front();
            end else begin
                exp_buf[b] = DEF;
                exp_und++;
            end
        end
        cs = 1'b0;
        wait_clk(HALF);
        check("busy in frame", busy, 1);
        check("miso_oe in frame", miso_oe, 1);
        for (int b = 0; b < n; b++) begin
            xfer_byte(b, inject && b == 0, inj);
            if (inject && b == 0) check("tx_ready after same-clk write", tx_ready, 0);
        end
        wait_clk(HALF);
        cs = 1'b1;
        wait_clk(2 * HALF);
        check("busy after frame", busy, 0);
        check("miso_oe after frame", miso_oe, 0);
        for (int b = 0; b < n; b++)
            check($sformatf("miso byte %0d", b), mi_buf[b], exp_buf[b]);
        check("rx_valid pulses", rx_got.size(), n);
        for (int b = 0; b < n && b < rx_got.size(); b++)
            check($sformatf("rx_data byte %0d", b), rx_got[b], mo_buf[b]);
        check("tx_underrun pulses", und_cnt - und0, exp_und);
        check("tx_ready after frame", tx_ready, model_q.size() == 0);
    endtask

    initial begin
        int und0, abt0, oe0, nb;

        vec[0] = '{queue: 1'b1, qdata: 8'hA5, mo: 8'h80, exp_mi: 8'hA5, exp_und: 0};
        vec[1] = '{queue: 1'b0, qdata: 8'h00, mo: 8'hFF, exp_mi: 8'h00, exp_und: 1};
        vec[2] = '{queue: 1'b1, qdata: 8'h3C, mo: 8'h01, exp_mi: 8'h3C, exp_und: 0};
        vec[3] = '{queue: 1'b1, qdata: 8'hFF, mo: 8'h5A, exp_mi: 8'hFF, exp_und: 0};

        // Reset state
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        check("reset miso", miso, 1);
        check("reset miso_oe", miso_oe, 0);
        check("reset tx_ready", tx_ready, 1);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 0);
        check("reset busy", busy, 0);
        check("reset tx_underrun", tx_underrun, 0);
        check("reset frame_abort", frame_abort, 0);

        // Table-driven single-byte frames
        foreach (vec[k]) begin
            und0 = und_cnt;
            if (vec[k].queue) push_tx(vec[k].qdata);
            mo_buf[0] = vec[k].mo;
            run_frame(1, 1'b0, 8'h00);
            check($sformatf("vec %0d miso", k), mi_buf[0], vec[k].exp_mi);
            check($sformatf("vec %0d underrun", k), und_cnt - und0, vec[k].exp_und);
        end

        // Two-byte frame, only one byte queued
        push_tx(8'h3C);
        mo_buf[0] = 8'h01;
        mo_buf[1] = 8'hFF;
        run_frame(2, 1'b0, 8'h00);
        check("two-byte second miso", mi_buf[1], 8'h00);

        // cs raised after 5 rising edges
        und0 = und_cnt;
        abt0 = abt_cnt;
        rx_got.delete();
        cs = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 5; i++) begin
            spi_clk = 1'b0;
            mosi    = i[0];
            wait_clk(HALF);
            spi_clk = 1'b1;
            wait_clk(HALF);
        end
        wait_clk(HALF);
        cs = 1'b1;
        wait_clk(2 * HALF);
        check("abort pulses", abt_cnt - abt0, 1);
        check("abort rx_valid", rx_got.size(), 0);
        check("abort underrun", und_cnt - und0, model_q.size() == 0);
        if (model_q.size() > 0) void'(model_q.pop_front());
        mo_buf[0] = 8'hC3;
        run_frame(1, 1'b0, 8'h00);

        // Write arriving on the same clk as the first fetch, buffer empty
        mo_buf[0] = 8'h11;
        mo_buf[1] = 8'h22;
        run_frame(2, 1'b1, 8'h5A);
        check("inject first byte", mi_buf[0], 8'h00);
        check("inject second byte", mi_buf[1], 8'h5A);

        // SCLK toggling while deselected
        push_tx(8'h77);
        oe0  = oe_cnt;
        und0 = und_cnt;
        rx_got.delete();
        for (int i = 0; i < 8; i++) begin
            spi_clk = 1'b0;
            mosi    = i[0];
            wait_clk(HALF);
            spi_clk = 1'b1;
            wait_clk(HALF);
        end
        check("idle sclk miso_oe", oe_cnt - oe0, 0);
        check("idle sclk rx_valid", rx_got.size(), 0);
        check("idle sclk underrun", und_cnt - und0, 0);
        check("idle sclk no fetch", tx_ready, 0);
        mo_buf[0] = 8'h3E;
        run_frame(1, 1'b0, 8'h00);
        check("byte kept across idle sclk", mi_buf[0], 8'h77);

        // Asynchronous reset mid-byte
        push_tx(8'h99);
        abt0 = abt_cnt;
        rx_got.delete();
        cs = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 3; i++) begin
            spi_clk = 1'b0;
            mosi    = 1'b1;
            wait_clk(HALF);
            spi_clk = 1'b1;
            wait_clk(HALF);
        end
        spi_clk = 1'b0;
        wait_clk(SYNC + 3);
        check("busy before reset", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst miso", miso, 1);
        check("async rst miso_oe", miso_oe, 0);
        check("async rst tx_ready", tx_ready, 1);
        check("async rst rx_data", rx_data, 8'h00);
        check("async rst busy", busy, 0);
        check("async rst rx_valid", rx_valid, 0);
        check("async rst tx_underrun", tx_underrun, 0);
        check("async rst frame_abort", frame_abort, 0);
        model_q.delete();
        cs      = 1'b1;
        spi_clk = 1'b1;
        mosi    = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4 * HALF);
        check("no abort after reset", abt_cnt - abt0, 0);
        check("no rx after reset", rx_got.size(), 0);
        push_tx(8'h42);
        mo_buf[0] = 8'hE7;
        run_frame(1, 1'b0, 8'h00);
        check("frame after reset", mi_buf[0], 8'h42);

        // Randomised frames against the queue model
        for (int k = 0; k < 25; k++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) mo_buf[b] = 8'($urandom);
            if (model_q.size() == 0 && $urandom_range(0, 1) == 1) push_tx(8'($urandom));
            run_frame(nb, 1'b0, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_spi_slave_responder
`default_nettype wire
